axi_lint_rw_arbiter: RTL

Arbitrates the LINT-style memory requests of the AXI read controller and the AXI write controller onto a single memory/interconnect port. Sits directly downstream of both controllers, between them and the L2 TCDM interconnect. Routes each response back to its originator using an in-order owner FIFO. Read and write bursts are interleaved fairly.

---
 rtl/axi_lint_rw_arbiter.sv | 131 +++++++++++++
 1 files changed

// File: rtl/axi_lint_rw_arbiter.sv
// axi_lint_rw_arbiter: merges read/write LINT requests onto one memory port,
// alternating between sides under contention and routing responses back in order.
//
// Ports:
//   clk, rst                      clock, async active-high reset
//   rd_req_i/rd_add_i/rd_size_i   read request channel
//   rd_gnt_o/rd_rdata_o/rd_r_valid_o  read grant and response
//   wr_req_i/wr_add_i/wr_wdata_i/wr_be_i/wr_size_i  write request channel
//   wr_gnt_o/wr_r_valid_o         write grant and acknowledge
//   mem_*                         shared memory port
//   err_o                         sticky: response seen with nothing outstanding
module axi_lint_rw_arbiter #(
    parameter int MEM_ADDR_WIDTH = 13,
    parameter int DATA_WIDTH     = 64,
    parameter int BE_WIDTH       = DATA_WIDTH / 8,
    parameter int OUTSTANDING    = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rd_req_i,
    input  logic [MEM_ADDR_WIDTH-1:0] rd_add_i,
    input  logic                      rd_size_i,
    output logic                      rd_gnt_o,
    output logic [DATA_WIDTH-1:0]     rd_rdata_o,
    output logic                      rd_r_valid_o,
    input  logic                      wr_req_i,
    input  logic [MEM_ADDR_WIDTH-1:0] wr_add_i,
    input  logic [DATA_WIDTH-1:0]     wr_wdata_i,
    input  logic [BE_WIDTH-1:0]       wr_be_i,
    input  logic                      wr_size_i,
    output logic                      wr_gnt_o,
    output logic                      wr_r_valid_o,
    output logic                      mem_req_o,
    output logic                      mem_wen_o,
    output logic [MEM_ADDR_WIDTH-1:0] mem_add_o,
    output logic [DATA_WIDTH-1:0]     mem_wdata_o,
    output logic [BE_WIDTH-1:0]       mem_be_o,
    output logic                      mem_size_o,
    input  logic                      mem_gnt_i,
    input  logic [DATA_WIDTH-1:0]     mem_rdata_i,
    input  logic                      mem_r_valid_i,
    output logic                      err_o
);

    localparam int CW = $clog2(OUTSTANDING + 1);
    localparam int PW = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;

    logic                   prio_q;
    logic [OUTSTANDING-1:0] own_q;
    logic [PW-1:0]          wptr_q;
    logic [PW-1:0]          rptr_q;
    logic [CW-1:0]          count_q;
    logic                   err_q;

    logic full;
    logic sel_rd;
    logic sel_wr;
    logic push;
    logic pop;
    logic head;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(OUTSTANDING - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full = (count_q == CW'(OUTSTANDING));

    // Selection never looks at mem_gnt_i, so there is no req/gnt loop.
    always_comb begin
        sel_rd = 1'b0;
        sel_wr = 1'b0;
        if (!full) begin
            if (rd_req_i && wr_req_i) begin
                sel_wr = prio_q;
                sel_rd = ~prio_q;
            end else begin
                sel_rd = rd_req_i;
                sel_wr = wr_req_i;
            end
        end
    end

    assign mem_req_o   = sel_rd | sel_wr;
    assign mem_wen_o   = ~sel_wr;
    assign mem_add_o   = sel_rd ? rd_add_i : wr_add_i;
    assign mem_size_o  = sel_rd ? rd_size_i : wr_size_i;
    assign mem_wdata_o = wr_wdata_i;
    assign mem_be_o    = wr_be_i;

    assign rd_gnt_o = sel_rd & mem_gnt_i;
    assign wr_gnt_o = sel_wr & mem_gnt_i;

    assign push = mem_req_o & mem_gnt_i;
    assign pop  = mem_r_valid_i & (count_q != '0);
    assign head = own_q[rptr_q];

    assign rd_r_valid_o = pop & ~head;
    assign wr_r_valid_o = pop & head;
    assign rd_rdata_o   = mem_rdata_i;
    assign err_o        = err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio_q  <= 1'b0;
            own_q   <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (push) begin
                own_q[wptr_q] <= sel_wr;
                wptr_q        <= ptr_inc(wptr_q);
                // Hand preference to the side that just lost out.
                prio_q        <= ~sel_wr;
            end
            if (pop) begin
                rptr_q <= ptr_inc(rptr_q);
            end
            if (push && !pop) begin
                count_q <= count_q + CW'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CW'(1);
            end
            if (mem_r_valid_i && count_q == '0) begin
                err_q <= 1'b1;
            end
        end
    end

endmodule
